// File: rtl/btn_debounce.sv
// Per-channel push-button conditioner: two-flop synchronizer, stability-window
// debouncer and registered one-cycle rise/fall strobes.
module btn_debounce #(
    parameter int unsigned Width        = 3,
    parameter int unsigned StableCycles = 60000,
    parameter bit          ResetVal     = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [Width-1:0] btn_i,
    output logic [Width-1:0] btn_o,
    output logic [Width-1:0] rise_o,
    output logic [Width-1:0] fall_o
);

    localparam int unsigned     CntW   = $clog2(StableCycles);
    localparam logic [CntW-1:0] CntMax = CntW'(StableCycles - 1);

    logic [Width-1:0] sync1;
    logic [Width-1:0] sync2;
    logic [Width-1:0] full;
    logic [CntW-1:0]  cnt [Width];

    // The window is cnt 0..CntMax followed by one "full" edge, so a level that
    // reaches sync2 after E1 is accepted on E(StableCycles+2).
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1  <= {Width{ResetVal}};
            sync2  <= {Width{ResetVal}};
            btn_o  <= {Width{ResetVal}};
            full   <= '0;
            rise_o <= '0;
            fall_o <= '0;
            // NOTE: the counter array is plain flops, not RAM, so it takes the
            // async reset like every other piece of state; an abandoned window
            // must not leak credit across a reset.
            for (int n = 0; n < int'(Width); n++) begin
                cnt[n] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments make sync1 -> sync2 a true two-stage
            // shift; blocking here would collapse the synchronizer to one flop.
            sync1  <= btn_i;
            sync2  <= sync1;
            rise_o <= '0;
            fall_o <= '0;
            for (int n = 0; n < int'(Width); n++) begin
                if (sync2[n] == btn_o[n]) begin
                    cnt[n]  <= '0;
                    full[n] <= 1'b0;
                end else if (cnt[n] != CntMax) begin
                    cnt[n] <= cnt[n] + CntW'(1);
                end else if (!full[n]) begin
                    full[n] <= 1'b1;
                end else begin
                    btn_o[n]  <= sync2[n];
                    rise_o[n] <= sync2[n];
                    fall_o[n] <= ~sync2[n];
                    cnt[n]    <= '0;
                    full[n]   <= 1'b0;
                end
            end
        end
    end

endmodule
